// File: rtl/aer_event_collector_pkg.sv
// Shared definitions for the AER event collector: default widths, event record and FSM states.
package snn_aer_pkg;

    localparam int AER_ADDR_W = 4;
    localparam int AER_TS_W   = 16;

    typedef struct packed {
        logic [AER_ADDR_W-1:0] addr;
        logic [AER_TS_W-1:0]   ts;
    } aer_event_t;

    typedef enum logic {
        IDLE = 1'b0,
        ACK  = 1'b1
    } aer_state_e;

    localparam logic [0:0] ST_IDLE = IDLE;
    localparam logic [0:0] ST_ACK  = ACK;

endpackage

// File: rtl/aer_event_collector_if.sv
// Spike handshake towards the priority handler and event stream towards the classifier.
interface aer_event_collector_if
    import snn_aer_pkg::*;
#(
    parameter int ADDR_W = AER_ADDR_W,
    parameter int TS_W   = AER_TS_W
);
    logic              spike_req;
    logic [ADDR_W-1:0] spike_addr;
    logic              spike_ack;
    logic              ev_valid;
    logic              ev_ready;
    logic [ADDR_W-1:0] ev_addr;
    logic [TS_W-1:0]   ev_ts;

    // master is the collector; slave is the handler/classifier side
    modport master (
        input  spike_req, spike_addr, ev_ready,
        output spike_ack, ev_valid, ev_addr, ev_ts
    );

    modport slave (
        output spike_req, spike_addr, ev_ready,
        input  spike_ack, ev_valid, ev_addr, ev_ts
    );

endinterface

// File: rtl/aer_sync_fifo.sv
// Show-ahead synchronous FIFO; the head word is on rdata whenever empty is low.
module aer_sync_fifo #(
    parameter int WIDTH = 20,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rdata,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    // full blocks a push even when a pop frees a slot in the same cycle
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            unique case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/aer_event_collector.sv
// Acknowledges AER spike requests one at a time, timestamps them and streams them out of a FIFO.
//   state | meaning
//   IDLE  | sample spike_req; push {addr, ts} and go to ACK when the FIFO has room
//   ACK   | spike_ack high for one cycle while the neuron clears its spike
module aer_event_collector
    import snn_aer_pkg::*;
#(
    parameter int ADDR_W = AER_ADDR_W,
    parameter int TS_W   = AER_TS_W,
    parameter int DEPTH  = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    aer_event_collector_if.master  bus,
    input  logic                   ts_clear,
    output logic [$clog2(DEPTH):0] fifo_count,
    output logic                   overrun
);
    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [TS_W-1:0]   ts;
    } ev_t;

    logic [0:0]      state;
    logic [TS_W-1:0] ts_cnt;
    logic            full;
    logic            empty;
    logic            push;
    ev_t             wr_ev;
    ev_t             rd_ev;

    assign push  = (state == ST_IDLE) && bus.spike_req && !full;
    assign wr_ev = '{addr: bus.spike_addr, ts: ts_cnt};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ts_cnt <= '0;
        end else if (ts_clear) begin
            ts_cnt <= '0;
        end else begin
            ts_cnt <= ts_cnt + TS_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            unique case (state)
                ST_IDLE: state <= push ? ST_ACK : ST_IDLE;
                ST_ACK:  state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    // a request only waits on a full FIFO while IDLE; ACK ignores spike_req
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overrun <= 1'b0;
        end else if ((state == ST_IDLE) && bus.spike_req && full) begin
            overrun <= 1'b1;
        end
    end

    assign bus.spike_ack = (state == ST_ACK);

    aer_sync_fifo #(
        .WIDTH (ADDR_W + TS_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .wdata (wr_ev),
        .pop   (bus.ev_ready),
        .rdata (rd_ev),
        .count (fifo_count),
        .full  (full),
        .empty (empty)
    );

    assign bus.ev_valid = ~empty;
    assign bus.ev_addr  = rd_ev.addr;
    assign bus.ev_ts    = rd_ev.ts;

endmodule

// File: tb/tb_aer_event_collector.sv
// Randomised and directed bench for aer_event_collector with a queue-based reference model.
module tb_aer_event_collector;
    localparam int AW    = 4;
    localparam int TW    = 4;
    localparam int DEPTH = 8;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          ts_clear = 1'b0;
    logic [CW-1:0] fifo_count;
    logic          overrun;

    aer_event_collector_if #(.ADDR_W(AW), .TS_W(TW)) bus ();

    aer_event_collector #(.ADDR_W(AW), .TS_W(TW), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus        (bus),
        .ts_clear   (ts_clear),
        .fifo_count (fifo_count),
        .overrun    (overrun)
    );

    always #5 clk = ~clk;

    typedef struct {
        int addr;
        int ts;
    } exp_t;

    exp_t        sb_q[$];
    int          m_count;
    int          m_ts;
    bit          m_ack;
    bit          m_overrun;
    int          n_cmp = 0;
    int          n_bad = 0;
    logic [15:0] pending;
    bit          hold_spikes;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // reference model: occupancy, ack flag, overrun and free-running timestamp
    initial begin
        m_count = 0; m_ts = 0; m_ack = 0; m_overrun = 0;
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                m_count = 0; m_ts = 0; m_ack = 0; m_overrun = 0;
                sb_q.delete();
            end else begin
                bit idle_req, dpush, dpop;
                idle_req = !m_ack && bus.spike_req;
                dpush    = idle_req && (m_count < DEPTH);
                if (idle_req && m_count == DEPTH) m_overrun = 1;
                dpop     = (m_count > 0) && bus.ev_ready;
                if (dpush) sb_q.push_back('{addr: int'(bus.spike_addr), ts: m_ts});
                m_count  = m_count + int'(dpush) - int'(dpop);
                m_ack    = dpush;
                m_ts     = ts_clear ? 0 : (m_ts + 1) % (1 << TW);
            end
        end
    end

    // monitor: compares DUT outputs each cycle and pops the scoreboard on each handshake
    initial begin
        forever begin
            @(negedge clk);
            #1;
            if (rst_n) begin
                check("spike_ack", int'(bus.spike_ack), int'(m_ack));
                check("ev_valid", int'(bus.ev_valid), int'(m_count > 0));
                check("fifo_count", int'(fifo_count), m_count);
                check("overrun", int'(overrun), int'(m_overrun));
                if (bus.ev_valid && bus.ev_ready) begin
                    if (sb_q.size() == 0) begin
                        check("sb_nonempty", 0, 1);
                    end else begin
                        exp_t e;
                        e = sb_q.pop_front();
                        check("ev_addr", int'(bus.ev_addr), e.addr);
                        check("ev_ts", int'(bus.ev_ts), e.ts);
                    end
                end
            end
        end
    end

    task automatic drive();
        int low;
        low = 0;
        for (int i = 15; i >= 0; i--) if (pending[i]) low = i;
        bus.spike_req  = |pending;
        bus.spike_addr = AW'(low);
    endtask

    // handler model: the acked (lowest) neuron drops its spike at the end of the ack cycle
    task automatic tick();
        @(negedge clk);
        if (bus.spike_ack && !hold_spikes && pending != 0) pending &= pending - 16'd1;
        drive();
    endtask

    task automatic wait_ts(input int v, input int budget);
        int n;
        n = 0;
        while (m_ts != v && n < budget) begin
            tick();
            n++;
        end
        check("wait_ts_bound", int'(m_ts == v), 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int acks[$];
        bit found;
        bus.spike_req = 0; bus.spike_addr = '0; bus.ev_ready = 0;
        pending = '0; hold_spikes = 0;
        rst_n = 0;
        repeat (3) @(negedge clk);
        check("rst_ack", int'(bus.spike_ack), 0);
        check("rst_valid", int'(bus.ev_valid), 0);
        check("rst_count", int'(fifo_count), 0);
        check("rst_overrun", int'(overrun), 0);
        rst_n = 1;

        // single event sampled at ts=10
        bus.ev_ready = 1;
        wait_ts(10, 40);
        pending = 16'h1 << 5;
        drive();
        tick();
        check("single_ack", int'(bus.spike_ack), 1);
        check("single_valid", int'(bus.ev_valid), 1);
        check("single_addr", int'(bus.ev_addr), 5);
        check("single_ts", int'(bus.ev_ts), 10);
        tick();
        check("single_drained", int'(fifo_count), 0);

        // burst of three pending neurons
        bus.ev_ready = 0;
        pending = (16'h1 << 2) | (16'h1 << 3) | (16'h1 << 7);
        drive();
        for (int i = 0; i < 20; i++) begin
            tick();
            if (bus.spike_ack) acks.push_back(i);
        end
        check("burst_acks", acks.size(), 3);
        if (acks.size() == 3) begin
            check("burst_gap0", acks[1] - acks[0], 2);
            check("burst_gap1", acks[2] - acks[1], 2);
        end
        check("burst_count", int'(fifo_count), 3);
        check("burst_head", int'(bus.ev_addr), 2);

        // continuous requests into a blocked consumer
        for (int i = 0; i < 30; i++) begin
            tick();
            if (pending == 0) pending = 16'hFFFF;
            drive();
        end
        check("full_count", int'(fifo_count), DEPTH);
        check("full_overrun", int'(overrun), 1);
        for (int i = 0; i < 4; i++) begin
            tick();
            if (pending == 0) pending = 16'hFFFF;
            drive();
            check("full_no_ack", int'(bus.spike_ack), 0);
        end
        bus.ev_ready = 1;
        tick();
        bus.ev_ready = 0;
        check("full_pop_count", int'(fifo_count), DEPTH - 1);
        found = 0;
        for (int i = 0; i < 2 && !found; i++) begin
            tick();
            if (bus.spike_ack) found = 1;
        end
        check("full_reack", int'(found), 1);

        // simultaneous push and pop at occupancy 4
        pending = '0;
        drive();
        bus.ev_ready = 1;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (fifo_count == CW'(4) && !bus.spike_ack) begin
                bus.ev_ready = 0;
                break;
            end
        end
        check("pp_pre_count", int'(fifo_count), 4);
        pending = 16'h1 << 11;
        bus.ev_ready = 1;
        drive();
        tick();
        bus.ev_ready = 0;
        check("pp_count", int'(fifo_count), 4);
        check("pp_ack", int'(bus.spike_ack), 1);
        tick();
        bus.ev_ready = 1;
        for (int i = 0; i < 20 && fifo_count != 0; i++) tick();
        check("drain_count", int'(fifo_count), 0);

        // timestamp wrap: captures at 15 and then 1
        wait_ts(15, 40);
        pending = (16'h1 << 1) | (16'h1 << 4);
        drive();
        tick();
        check("wrap_ack0", int'(bus.spike_ack), 1);
        check("wrap_addr0", int'(bus.ev_addr), 1);
        check("wrap_ts0", int'(bus.ev_ts), 15);
        tick();
        tick();
        check("wrap_ack1", int'(bus.spike_ack), 1);
        check("wrap_addr1", int'(bus.ev_addr), 4);
        check("wrap_ts1", int'(bus.ev_ts), 1);
        tick();

        // ts_clear: capture three cycles later reads 2
        ts_clear = 1;
        tick();
        ts_clear = 0;
        tick();
        tick();
        pending = 16'h1 << 6;
        drive();
        tick();
        check("clear_ack", int'(bus.spike_ack), 1);
        check("clear_ts", int'(bus.ev_ts), 2);
        tick();

        // asynchronous reset in the middle of an ack
        bus.ev_ready = 0;
        hold_spikes = 1;
        pending = 16'h1 << 9;
        drive();
        tick();
        check("rst_mid_ack_pre", int'(bus.spike_ack), 1);
        #2 rst_n = 0;
        #1;
        check("rst_mid_ack", int'(bus.spike_ack), 0);
        check("rst_mid_valid", int'(bus.ev_valid), 0);
        check("rst_mid_count", int'(fifo_count), 0);
        hold_spikes = 0;
        tick();
        rst_n = 1;
        found = 0;
        for (int i = 0; i < 4 && !found; i++) begin
            tick();
            if (bus.spike_ack) found = 1;
        end
        check("rst_reack", int'(found), 1);
        check("rst_reack_addr", int'(bus.ev_addr), 9);

        // randomised traffic
        for (int i = 0; i < 400; i++) begin
            tick();
            if ($urandom_range(0, 3) == 0) pending |= 16'($urandom_range(1, 65535));
            bus.ev_ready = 1'($urandom_range(0, 1));
            ts_clear = ($urandom_range(0, 15) == 0);
            drive();
        end
        pending = '0;
        ts_clear = 0;
        bus.ev_ready = 1;
        drive();
        for (int i = 0; i < 30 && (fifo_count != 0 || bus.spike_ack); i++) tick();
        tick();
        check("final_count", int'(fifo_count), 0);
        check("final_sb_empty", sb_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
